min_serial_3b: RTL and testbench



---
 rtl/min_serial_3b.sv | 103 ++++++++++
 tb/tb_min_serial_3b.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/min_serial_3b.sv
// Digit-serial unsigned minimum selector.
// Operands are captured on a valid/ready handshake, then compared one 3-bit digit per
// clock, MSB digit first. The first unequal digit decides the result; the remaining
// digits are still visited so latency is always N compare cycles.
module min_serial_3b #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] min_val,
  output logic         sel_b
);

  localparam int unsigned N    = W / 3;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);

  typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;
  typedef enum logic [1:0] {DecEq, DecALt, DecBLt} dec_e;

  state_e          state_q;
  dec_e            dec_q;
  dec_e            dec_d;
  logic [IdxW-1:0] idx_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [2:0]      da;
  logic [2:0]      db;

  // Current digit pair and the decision after folding it in; a decided result is sticky.
  always_comb begin
    da    = a_q[3*idx_q +: 3];
    db    = b_q[3*idx_q +: 3];
    dec_d = dec_q;
    if (dec_q == DecEq) begin
      if (da < db) begin
        dec_d = DecALt;
      end else if (da > db) begin
        dec_d = DecBLt;
      end
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      dec_q     <= DecEq;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      min_val   <= '0;
      sel_b     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            dec_q    <= DecEq;
            idx_q    <= IdxLast;
            in_ready <= 1'b0;
            state_q  <= StCmp;
          end else begin
            // Raises in_ready on the first edge after reset release.
            in_ready <= 1'b1;
          end
        end
        StCmp: begin
          dec_q <= dec_d;
          if (idx_q == '0) begin
            // Ties fall through to a with sel_b low.
            out_valid <= 1'b1;
            min_val   <= (dec_d == DecBLt) ? b_q : a_q;
            sel_b     <= (dec_d == DecBLt);
            state_q   <= StDone;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_min_serial_3b.sv
// Directed and randomized bench for min_serial_3b against a plain min/select model.
module tb_min_serial_3b;

  localparam int unsigned W = 24;
  localparam int unsigned N = W / 3;
  localparam int unsigned Guard = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] min_val;
  logic         sel_b;

  int tests = 0;
  int fails = 0;

  min_serial_3b #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .min_val   (min_val),
    .sel_b     (sel_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_min(input logic [W-1:0] x, input logic [W-1:0] y);
    return (y < x) ? y : x;
  endfunction

  function automatic logic [W-1:0] model_sel(input logic [W-1:0] x, input logic [W-1:0] y);
    return (y < x) ? W'(1) : W'(0);
  endfunction

  // Accept one pair with out_ready high, check latency, result and hand-back.
  task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb);
    int cnt;
    cnt = 0;
    out_ready = 1'b1;
    while (!in_ready && cnt < Guard) begin
      tick();
      cnt++;
    end
    chk({tag, "_ready"}, W'(in_ready), W'(1));
    a = xa;
    b = xb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = ~xa;
    b = ~xb;
    cnt = 0;
    while (!out_valid && cnt < Guard) begin
      tick();
      cnt++;
    end
    chk({tag, "_lat"}, W'(cnt), W'(N));
    chk({tag, "_min"}, min_val, model_min(xa, xb));
    chk({tag, "_sel"}, W'(sel_b), model_sel(xa, xb));
    tick();
    chk({tag, "_ovdone"}, W'(out_valid), W'(0));
    chk({tag, "_irdy"}, W'(in_ready), W'(1));
    chk({tag, "_hold"}, min_val, model_min(xa, xb));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] emin;
    logic [W-1:0] esel;
    int           cnt;
    logic         hs;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #12;
    chk("rst_irdy", W'(in_ready), W'(0));
    chk("rst_ov", W'(out_valid), W'(0));
    chk("rst_min", min_val, W'(0));
    chk("rst_sel", W'(sel_b), W'(0));
    rst_n = 1'b1;
    tick();
    chk("rel_irdy", W'(in_ready), W'(1));

    // Decision at the MSB digit, at the LSB digit, and a tie.
    run_op("msb", 24'h800000, 24'h7FFFFF);
    run_op("lsb_a", 24'hABCDE4, 24'hABCDE5);
    run_op("lsb_b", 24'hABCDE5, 24'hABCDE4);
    run_op("tie", 24'h123456, 24'h123456);

    // Backpressure: result must hold while out_ready is low, new operands ignored.
    out_ready = 1'b0;
    a = 24'h000010;
    b = 24'h000001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      a = 24'hFFFFFF;
      b = 24'h000000;
      chk("bp_ov", W'(out_valid), W'(1));
      chk("bp_min", min_val, 24'h000001);
      chk("bp_sel", W'(sel_b), W'(1));
      chk("bp_irdy", W'(in_ready), W'(0));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_irdy", W'(in_ready), W'(1));
    chk("bp_release_ov", W'(out_valid), W'(0));
    tick();
    chk("bp_no_capture", W'(out_valid), W'(0));

    // Abort in the 4th compare cycle.
    a = 24'h000003;
    b = 24'h000002;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_irdy", W'(in_ready), W'(0));
    chk("abort_ov", W'(out_valid), W'(0));
    chk("abort_min", min_val, W'(0));
    chk("abort_sel", W'(sel_b), W'(0));
    #2;
    rst_n = 1'b1;
    tick();
    chk("abort_rel_irdy", W'(in_ready), W'(1));
    run_op("post_abort", 24'h000007, 24'h000007);

    // Random pairs with random idle gaps, ignored in_valid pulses and random out_ready.
    for (int n = 0; n < 1500; n++) begin
      in_valid = 1'b0;
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        a = W'($urandom);
        tick();
      end
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ W'($urandom_range(1, 7));
        2: rb = ra ^ (W'($urandom_range(1, 7)) << (3 * $urandom_range(0, N - 1)));
        default: rb = W'($urandom);
      endcase
      emin = model_min(ra, rb);
      esel = model_sel(ra, rb);
      a = ra;
      b = rb;
      in_valid = 1'b1;
      tick();
      cnt = 0;
      while (!out_valid && cnt < Guard) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        a = W'($urandom);
        b = W'($urandom);
        tick();
        cnt++;
      end
      chk("rnd_lat", W'(cnt), W'(N));
      cnt = 0;
      hs = 1'b0;
      while (!hs && cnt < Guard) begin
        chk("rnd_min", min_val, emin);
        chk("rnd_sel", W'(sel_b), esel);
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        hs = out_valid && out_ready;
        tick();
        cnt++;
      end
      chk("rnd_hs", W'(hs), W'(1));
      chk("rnd_ovdone", W'(out_valid), W'(0));
      chk("rnd_irdy", W'(in_ready), W'(1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
